// File: rtl/ps2_rx_fifo_if.sv
// Read-side bundle of the PS/2 receiver: FIFO pop port plus sticky error flags.
// master = receiver, slave = bus peripheral draining the bytes.
interface ps2_rx_fifo_if #(
  parameter int ADDR_W = 3
);
  logic            rd_en;
  logic            clr_err;
  logic [7:0]      dout;
  logic            valid;
  logic [ADDR_W:0] count;
  logic            overflow;
  logic            parity_err;
  logic            frame_err;

  modport master (
    input  rd_en, clr_err,
    output dout, valid, count,
    output overflow, parity_err, frame_err
  );

  modport slave (
    output rd_en, clr_err,
    input  dout, valid, count,
    input  overflow, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: filtered clock, 11-bit framing, FWFT byte FIFO.
// Optional in-frame watchdog: define PS2_RX_TIMEOUT_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int ADDR_W      = 3,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk,
  input  logic ps2_data,
  input  logic rx_en,
  ps2_rx_fifo_if.master bus
);

  typedef enum logic [1:0] {
    IDLE, DATA, PARITY, STOP
  } state_t;

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FLIM = FW'(FILTER_LEN - 1);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(FIFO_DEPTH);

  logic [1:0]            clk_sync;
  logic [1:0]            dat_sync;
  logic [FW-1:0]         fcnt;
  logic                  fclk;
  logic                  fclk_d;
  logic                  strobe;
  logic [FILTER_LEN-1:0] dly;
  logic                  rx_bit;

  state_t      state_q, state_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic        par_q, par_d;
  logic        push_d, push_q;
  logic        perr_ev, ferr_ev, ovf_ev;
  logic        tmo_fire;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0] cnt_q;
  logic            valid;
  logic            full;
  logic            do_push, do_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync <= 2'b11;
      dat_sync <= 2'b11;
      fcnt     <= '0;
      fclk     <= 1'b1;
      fclk_d   <= 1'b1;
      dly      <= '1;
    end else begin
      clk_sync <= {clk_sync[0], ps2_clk};
      dat_sync <= {dat_sync[0], ps2_data};
      fclk_d   <= fclk;
      dly      <= FILTER_LEN'({dly, dat_sync[1]});
      if (clk_sync[1] == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FLIM) begin
        fclk <= clk_sync[1];
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // data is delayed to match the filter latency on the clock path
  assign strobe = fclk_d & ~fclk;
  assign rx_bit = dly[FILTER_LEN-1];

`ifdef PS2_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if (strobe || state_q == IDLE) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_fire = (state_q != IDLE) && !strobe &&
                    (tmo_q == TW'(TIMEOUT_CYC - 1));
`else
  // never true: the FSM waits for strobes indefinitely
  assign tmo_fire = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    push_d  = 1'b0;
    perr_ev = 1'b0;
    ferr_ev = 1'b0;
    if (tmo_fire) begin
      state_d = IDLE;
      sh_d    = '0;
      ferr_ev = 1'b1;
    end else if (strobe) begin
      unique case (state_q)
        IDLE: begin
          if (rx_bit) begin
            ferr_ev = 1'b1;
          end else if (rx_en) begin
            state_d = DATA;
            bit_d   = 3'd0;
            sh_d    = '0;
          end
        end
        DATA: begin
          sh_d[bit_q] = rx_bit;
          bit_d       = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = rx_bit;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (!rx_bit) begin
            ferr_ev = 1'b1;
          end else if (^{sh_q, par_q}) begin
            push_d = 1'b1;
          end else begin
            perr_ev = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      push_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
      push_q  <= push_d;
    end
  end

  assign valid   = (cnt_q != '0);
  assign full    = (cnt_q == FULL_CNT);
  assign do_pop  = bus.rd_en & valid;
  // a pop in the same cycle frees the slot even when full
  assign do_push = push_q & (~full | do_pop);
  assign ovf_ev  = push_q & full & ~do_pop;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= sh_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      wr_ptr <= wr_ptr + ADDR_W'(do_push);
      rd_ptr <= rd_ptr + ADDR_W'(do_pop);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.overflow   <= 1'b0;
      bus.parity_err <= 1'b0;
      bus.frame_err  <= 1'b0;
    end else begin
      if (ovf_ev) bus.overflow <= 1'b1;
      else if (bus.clr_err) bus.overflow <= 1'b0;
      if (perr_ev) bus.parity_err <= 1'b1;
      else if (bus.clr_err) bus.parity_err <= 1'b0;
      if (ferr_ev) bus.frame_err <= 1'b1;
      else if (bus.clr_err) bus.frame_err <= 1'b0;
    end
  end

  assign bus.dout  = valid ? mem[rd_ptr] : 8'h00;
  assign bus.valid = valid;
  assign bus.count = cnt_q;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Scoreboard bench for ps2_rx_fifo: PS/2 frames in, queue model of the byte FIFO.
// Covers the PS2_RX_TIMEOUT_EN build as well when that macro is defined.
module tb_ps2_rx_fifo;
  localparam int FILTER_LEN  = 4;
  localparam int FIFO_DEPTH  = 8;
  localparam int ADDR_W      = 3;
  localparam int TIMEOUT_CYC = 300;
  localparam int HALF        = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic rx_en = 1'b1;

  ps2_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

  ps2_rx_fifo #(
    .FILTER_LEN (FILTER_LEN),
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .ps2_clk (ps2_clk),
    .ps2_data(ps2_data),
    .rx_en   (rx_en),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  logic ovf_exp = 1'b0;
  logic perr_exp = 1'b0;
  logic ferr_exp = 1'b0;
  logic [10:0] v;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // pops are checked whenever the DUT presents a byte while rd_en is high
  always @(negedge clk) begin
    if (!rst && bus.rd_en && bus.valid) begin
      if (exp_q.size() == 0) chk("pop_unexpected", bus.valid, 0);
      else chk("pop_dout", bus.dout, exp_q.pop_front());
    end
  end

  function automatic logic [10:0] frame(input logic [7:0] b, input int kind);
    logic p;
    logic s;
    p = ~(^b) ^ kind[0];
    s = ~kind[1];
    return {s, p, b, 1'b0};
  endfunction

  task automatic check_state(input string tag);
    chk({tag, "_count"}, bus.count, exp_q.size());
    chk({tag, "_valid"}, bus.valid, exp_q.size() != 0);
    if (exp_q.size() != 0) chk({tag, "_head"}, bus.dout, exp_q[0]);
    chk({tag, "_overflow"}, bus.overflow, ovf_exp);
    chk({tag, "_parity_err"}, bus.parity_err, perr_exp);
    chk({tag, "_frame_err"}, bus.frame_err, ferr_exp);
  endtask

  task automatic send_bits(input logic [10:0] f, input int lo, input int hi,
                           input bit pop_at_push);
    for (int i = lo; i <= hi; i++) begin
      ps2_data = f[i];
      tick(HALF);
      ps2_clk = 1'b0;
      if (i == 10 && pop_at_push) begin
        // 2 sync + FILTER_LEN filter + 1 cycle lands on the push cycle
        tick(FILTER_LEN + 3);
        bus.rd_en = 1'b1;
        tick(1);
        bus.rd_en = 1'b0;
        tick(HALF - FILTER_LEN - 4);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
  endtask

  // kind: 0 good, 1 bad parity, 2 stop=0, 3 both
  task automatic send_frame(input logic [7:0] b, input int kind,
                            input bit pop_at_push);
    if (kind == 0) begin
      if (exp_q.size() < FIFO_DEPTH || pop_at_push) exp_q.push_back(b);
      else ovf_exp = 1'b1;
    end else if (kind == 1) begin
      perr_exp = 1'b1;
    end else begin
      ferr_exp = 1'b1;
    end
    send_bits(frame(b, kind), 0, 10, pop_at_push);
    tick(HALF);
  endtask

  task automatic clear_err();
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    ovf_exp  = 1'b0;
    perr_exp = 1'b0;
    ferr_exp = 1'b0;
    tick(1);
  endtask

  task automatic drain(input int n);
    bus.rd_en = 1'b1;
    tick(n);
    bus.rd_en = 1'b0;
    tick(1);
  endtask

  initial begin
    bus.rd_en   = 1'b0;
    bus.clr_err = 1'b0;
    tick(3);
    chk("reset_count", bus.count, 0);
    chk("reset_valid", bus.valid, 0);
    chk("reset_dout", bus.dout, 0);
    chk("reset_flags", {bus.overflow, bus.parity_err, bus.frame_err}, 0);
    rst = 1'b0;
    tick(5);

    send_frame(8'h1C, 0, 0);
    check_state("t1");
    drain(1);
    check_state("t1_pop");

    send_frame(8'hF0, 0, 0);
    send_frame(8'h1C, 0, 0);
    send_frame(8'h5A, 0, 0);
    check_state("t2");
    for (int i = 0; i < 3; i++) begin
      bus.rd_en = 1'b1;
      tick(1);
      bus.rd_en = 1'b0;
      tick(1);
      check_state("t2_pop");
    end

    send_frame(8'h1C, 1, 0);
    check_state("t3_perr");
    clear_err();
    check_state("t3_clr");

    for (int i = 0; i < FIFO_DEPTH; i++) send_frame(8'($urandom), 0, 0);
    check_state("t4_full");
    send_frame(8'h99, 0, 0);
    check_state("t4_ovf");
    clear_err();
    send_frame(8'h77, 0, 1);
    check_state("t4_pushpop");
    drain(FIFO_DEPTH + 2);
    check_state("t4_drain");

    v = '1;
    send_bits(v, 0, 0, 0);
    tick(HALF);
    ferr_exp = 1'b1;
    check_state("start_err");
    clear_err();

    // rx_en low: nothing starts, the 1-bits seen in IDLE flag framing
    rx_en = 1'b0;
    send_bits(frame(8'h00, 0), 0, 10, 0);
    tick(HALF);
    ferr_exp = 1'b1;
    check_state("rx_dis");
    rx_en = 1'b1;
    clear_err();

    for (int i = 0; i < 3; i++) begin
      ps2_data = 1'b0;
      ps2_clk  = 1'b0;
      tick(2);
      ps2_clk  = 1'b1;
      tick(10);
      ps2_data = 1'b1;
      tick(10);
    end
    check_state("glitch");
    send_frame(8'hC3, 0, 0);
    check_state("glitch_next");
    drain(2);

    exp_q.push_back(8'h6B);
    v = frame(8'h6B, 0);
    send_bits(v, 0, 3, 0);
    rx_en = 1'b0;
    send_bits(v, 4, 10, 0);
    tick(HALF);
    rx_en = 1'b1;
    check_state("rx_en_mid");

    send_bits(frame(8'h2E, 0), 0, 4, 0);
    rst = 1'b1;
    tick(3);
    exp_q.delete();
    ovf_exp  = 1'b0;
    perr_exp = 1'b0;
    ferr_exp = 1'b0;
    check_state("rst_mid");
    rst = 1'b0;
    tick(5);
    send_frame(8'h2E, 0, 0);
    check_state("rst_next");
    drain(2);

    v = frame(8'hA5, 0);
    send_bits(v, 0, 4, 0);
`ifdef PS2_RX_TIMEOUT_EN
    tick(TIMEOUT_CYC + 20);
    ferr_exp = 1'b1;
    check_state("tmo");
    clear_err();
    send_frame(8'h3C, 0, 0);
    check_state("tmo_next");
`else
    tick(2 * TIMEOUT_CYC);
    check_state("stall");
    exp_q.push_back(8'hA5);
    send_bits(v, 5, 10, 0);
    tick(HALF);
    check_state("stall_done");
`endif
    drain(2);

    for (int it = 0; it < 40; it++) begin
      int r;
      int kind;
      r = $urandom_range(0, 9);
      kind = (r < 6) ? 0 : r - 6;
      send_frame(8'($urandom), kind, 0);
      check_state("rnd");
      if ($urandom_range(0, 2) == 0) begin
        drain($urandom_range(1, FIFO_DEPTH + 2));
        check_state("rnd_drain");
      end
      if ($urandom_range(0, 4) == 0) clear_err();
    end
    drain(FIFO_DEPTH + 1);
    check_state("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
